// File: rtl/imem_fetch_ctrl.sv
// rtl/imem_fetch_ctrl.sv - single-outstanding instruction fetch controller (IDLE/REQ/WAIT/HOLD)
// Optional misaligned-fetch trap enabled by defining IMEM_FETCH_ALIGN_CHECK_EN.
module imem_fetch_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_addr,
  input  logic        pc_valid,
  input  logic        flush,
  output logic        pc_stall,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  input  logic        id_ready,
  output logic        fetch_fault
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t      state;
  logic [31:0] addr_q;
  logic        drop_q;
  logic        accept;
  logic        misaligned;

  assign accept   = ((state == IDLE) || ((state == HOLD) && id_ready)) && pc_valid && !flush;
  assign pc_stall = !accept;

`ifdef IMEM_FETCH_ALIGN_CHECK_EN
  assign misaligned = |pc_addr[1:0];
  assign mem_addr   = addr_q;
`else
  assign misaligned = 1'b0;
  assign mem_addr   = {addr_q[31:2], 2'b00};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      addr_q      <= 32'h0;
      drop_q      <= 1'b0;
      mem_req     <= 1'b0;
      id_valid    <= 1'b0;
      id_instr    <= NOP;
      id_pc       <= 32'h0;
      fetch_fault <= 1'b0;
    end else begin
      case (state)
        REQ: begin
          if (flush) begin
            state   <= IDLE;
            mem_req <= 1'b0;
          end else if (mem_gnt) begin
            state   <= WAIT;
            mem_req <= 1'b0;
          end
        end
        WAIT: begin
          // A response that races or follows a flush belongs to the dead path.
          if (mem_rvalid) begin
            if (flush || drop_q) begin
              state  <= IDLE;
              drop_q <= 1'b0;
            end else begin
              state    <= HOLD;
              id_valid <= 1'b1;
              id_instr <= mem_rdata;
              id_pc    <= addr_q;
            end
          end else if (flush) begin
            drop_q <= 1'b1;
          end
        end
        HOLD: begin
          if (flush || id_ready) begin
            state       <= IDLE;
            id_valid    <= 1'b0;
            fetch_fault <= 1'b0;
          end
        end
        default: ;
      endcase

      // accept only fires from IDLE or a consumed HOLD, so it overrides the case above.
      if (accept) begin
        addr_q <= pc_addr;
        if (misaligned) begin
          state       <= HOLD;
          id_valid    <= 1'b1;
          id_instr    <= NOP;
          id_pc       <= pc_addr;
          fetch_fault <= 1'b1;
        end else begin
          state   <= REQ;
          mem_req <= 1'b1;
        end
      end
    end
  end

endmodule
